// File: rtl/trap_ctrl_pkg.sv
// Shared trap types: FSM state, cause codes, privilege modes and the registered trap payload.
package trap_ctrl_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CODE_W = XLEN - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        FLUSH  = 2'd2
    } trap_state_t;

    // Privilege mode encoding as delivered by the CSR file
    localparam logic [1:0] MODE_U = 2'b00;
    localparam logic [1:0] MODE_S = 2'b01;
    localparam logic [1:0] MODE_M = 2'b11;

    localparam int unsigned I_ADDR_MISALIGNED = 0;
    localparam int unsigned I_ILLEGAL         = 2;
    localparam int unsigned BREAKPOINT        = 3;
    localparam int unsigned ECALL_U           = 8;
    localparam int unsigned ECALL_S           = 9;
    localparam int unsigned ECALL_M           = 11;

    localparam int unsigned M_EXT   = 11;
    localparam int unsigned M_TIMER = 7;
    localparam int unsigned S_EXT   = 9;
    localparam int unsigned S_TIMER = 5;
    localparam int unsigned U_EXT   = 8;
    localparam int unsigned U_TIMER = 4;
    localparam int unsigned U_SOFT  = 0;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] pc;
        logic            m_ret;
        logic            s_ret;
        logic            u_ret;
    } trap_out_t;

    function automatic logic [XLEN-1:0] mk_cause(input logic irq, input int unsigned code);
        return {irq, CODE_W'(code)};
    endfunction

endpackage

// File: rtl/trap_ctrl_irq_sync.sv
// Two-flop synchronizer for one asynchronous interrupt line; both flops reset to 0.
module irq_sync (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap arbiter feeding the CSR file: picks one interrupt/exception/xRET per instruction boundary.
// Define TRAP_IRQ_SYNC_EN to pass external interrupt lines through 2-flop synchronizers.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            ex_valid,
    input  logic            stall,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_i_misaligned,
    input  logic            ex_illegal,
    input  logic            ex_ebreak,
    input  logic            ex_ecall,
    input  logic            ex_mret,
    input  logic            ex_sret,
    input  logic            ex_uret,
    input  logic [1:0]      current_mode,
    input  logic            m_eie,
    input  logic            m_tie,
    input  logic            s_eie,
    input  logic            s_tie,
    input  logic            u_eie,
    input  logic            u_tie,
    input  logic            u_sie,
    input  logic            m_timer,
    input  logic            s_timer,
    input  logic            u_timer,
    input  logic            ext_m_irq,
    input  logic            ext_s_irq,
    input  logic            ext_u_irq,
    output logic            m_interrupt,
    output logic            s_interrupt,
    output logic            u_interrupt,
    output logic            exception_pending,
    output logic [XLEN-1:0] cause,
    output logic [XLEN-1:0] pc_exc,
    output logic            m_ret,
    output logic            s_ret,
    output logic            u_ret,
    output logic            flush
);

    localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);

`ifdef TRAP_IRQ_SYNC_EN
    irq_sync u_sync_m (.clk(clk), .nrst(nrst), .d(ext_m_irq), .q(m_interrupt));
    irq_sync u_sync_s (.clk(clk), .nrst(nrst), .d(ext_s_irq), .q(s_interrupt));
    irq_sync u_sync_u (.clk(clk), .nrst(nrst), .d(ext_u_irq), .q(u_interrupt));
`else
    assign m_interrupt = ext_m_irq;
    assign s_interrupt = ext_s_irq;
    assign u_interrupt = ext_u_irq;
`endif

    trap_state_t state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    trap_out_t out_q, out_d, trap_sel;
    logic pend_d, flush_d, hit, multi_xret;

    // Priority mux; u_sie arrives already combined with the software-pending bit kept in the CSR file
    always_comb begin
        trap_sel   = '0;
        hit        = 1'b1;
        multi_xret = (ex_mret & ex_sret) | (ex_mret & ex_uret) | (ex_sret & ex_uret);
        trap_sel.pc = ex_pc;
        if (m_interrupt && m_eie)          trap_sel.cause = mk_cause(1'b1, M_EXT);
        else if (m_timer && m_tie)         trap_sel.cause = mk_cause(1'b1, M_TIMER);
        else if (s_interrupt && s_eie)     trap_sel.cause = mk_cause(1'b1, S_EXT);
        else if (s_timer && s_tie)         trap_sel.cause = mk_cause(1'b1, S_TIMER);
        else if (u_interrupt && u_eie)     trap_sel.cause = mk_cause(1'b1, U_EXT);
        else if (u_timer && u_tie)         trap_sel.cause = mk_cause(1'b1, U_TIMER);
        else if (u_sie)                    trap_sel.cause = mk_cause(1'b1, U_SOFT);
        else if (ex_i_misaligned)          trap_sel.cause = mk_cause(1'b0, I_ADDR_MISALIGNED);
        else if (ex_illegal || multi_xret) trap_sel.cause = mk_cause(1'b0, I_ILLEGAL);
        else if (ex_ebreak)                trap_sel.cause = mk_cause(1'b0, BREAKPOINT);
        else if (ex_ecall) begin
            case (current_mode)
                MODE_U:  trap_sel.cause = mk_cause(1'b0, ECALL_U);
                MODE_S:  trap_sel.cause = mk_cause(1'b0, ECALL_S);
                default: trap_sel.cause = mk_cause(1'b0, ECALL_M);
            endcase
        end else if (ex_mret || ex_sret || ex_uret) begin
            trap_sel.m_ret = ex_mret;
            trap_sel.s_ret = ex_sret;
            trap_sel.u_ret = ex_uret;
        end else begin
            hit = 1'b0;
        end
    end

    // Next-state and next-output logic; outputs are all registered below
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        out_d   = '0;
        pend_d  = 1'b0;
        flush_d = 1'b0;
        case (state)
            IDLE: begin
                if (ex_valid && !stall && hit) begin
                    state_d = COMMIT;
                    out_d   = trap_sel;
                    pend_d  = 1'b1;
                    flush_d = 1'b1;
                end
            end
            COMMIT: begin
                state_d = FLUSH;
                cnt_d   = CNT_W'(FLUSH_CYCLES);
                flush_d = 1'b1;
            end
            FLUSH: begin
                if (cnt == CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt - CNT_W'(1);
                    flush_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state             <= IDLE;
            cnt               <= '0;
            out_q             <= '0;
            exception_pending <= 1'b0;
            flush             <= 1'b0;
        end else begin
            state             <= state_d;
            cnt               <= cnt_d;
            out_q             <= out_d;
            exception_pending <= pend_d;
            flush             <= flush_d;
        end
    end

    assign cause  = out_q.cause;
    assign pc_exc = out_q.pc;
    assign m_ret  = out_q.m_ret;
    assign s_ret  = out_q.s_ret;
    assign u_ret  = out_q.u_ret;

endmodule
